bar_stream_gen: RTL and testbench

BAR_STREAM_GEN -- requirements
Module: bar_stream_gen

---
 rtl/bar_stream_gen.sv | 128 ++++++++++++
 tb/tb_bar_stream_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_stream_gen.sv
// Walks one frame of display columns and emits a bar height for each column.
// Each height is derived from a 1-cycle-latency spectrum RAM read.
module bar_stream_gen #(
    parameter int NUM_COL     = 800,
    parameter int COL_PER_BIN = 8,
    parameter int MAG_SHIFT   = 6,
    parameter int GAP_EN      = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        FrameReq,
    input  logic        Pace,
    output logic [6:0]  MagAddr,
    input  logic [15:0] MagData,
    output logic        NewFrame,
    output logic        Start,
    output logic [6:0]  Bar,
    output logic        Busy,
    output logic        Done
);

    localparam int                COL_W    = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [COL_W-1:0] CPB      = COL_W'(COL_PER_BIN);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

    typedef enum logic [2:0] {
        IDLE,
        NEWF,
        WAIT,
        FETCH,
        CALC,
        EMIT,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [6:0]         mag_addr_q, mag_addr_d;
    logic [6:0]         bar_q, bar_d;
    logic               newframe_q, newframe_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [15:0]        mag_s;
    logic [6:0]         height;
    logic               is_gap;

    always_comb begin
        mag_s  = MagData >> MAG_SHIFT;
        is_gap = (GAP_EN != 0) && ((col_q % CPB) == (CPB - 1'b1));
        height = (mag_s > 16'd127) ? 7'd127 : mag_s[6:0];
        if (is_gap) begin
            height = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        mag_addr_d = mag_addr_q;
        bar_d      = bar_q;
        unique case (state_q)
            IDLE:  if (FrameReq) state_d = NEWF;
            NEWF: begin
                col_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Address is loaded on entry so it is already valid during FETCH.
                if (Pace) begin
                    mag_addr_d = 7'(col_q / CPB);
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = CALC;
            CALC: begin
                bar_d   = height;
                state_d = EMIT;
            end
            EMIT: begin
                if (col_q == LAST_COL) begin
                    state_d = FIN;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = WAIT;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pulse outputs are registered copies of the state being entered.
        newframe_d = (state_d == NEWF);
        start_d    = (state_d == EMIT);
        done_d     = (state_d == FIN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            mag_addr_q <= '0;
            bar_q      <= '0;
            newframe_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            mag_addr_q <= mag_addr_d;
            bar_q      <= bar_d;
            newframe_q <= newframe_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign MagAddr  = mag_addr_q;
    assign Bar      = bar_q;
    assign NewFrame = newframe_q;
    assign Start    = start_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_bar_stream_gen.sv
// Bench for bar_stream_gen: default-parameter instance plus a 4-column, no-gap instance.
module tb_bar_stream_gen;

    logic        Clock = 1'b0;
    logic        Reset, FrameReq, FrameReq2, Pace;
    logic [6:0]  MagAddr, Bar, MagAddr2, Bar2;
    logic [15:0] MagData, MagData2;
    logic        NewFrame, Start, Busy, Done;
    logic        NewFrame2, Start2, Busy2, Done2;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [128];
    int pace_mode = 0;
    int pcnt = 0;
    int cyc = 0;

    int nf_cnt = 0, start_cnt = 0, done_cnt = 0, busy_err = 0, done_cyc = 0;
    int nf2_cnt = 0, start2_cnt = 0, done2_cnt = 0, done2_cyc = 0;
    bit in_frame = 1'b0;
    logic [6:0] bar_h[$], addr_h[$], bar2_h[$], addr2_h[$];
    int cyc_h[$], cyc2_h[$];

    bar_stream_gen dut (
        .Clock(Clock), .Reset(Reset), .FrameReq(FrameReq), .Pace(Pace),
        .MagAddr(MagAddr), .MagData(MagData), .NewFrame(NewFrame), .Start(Start),
        .Bar(Bar), .Busy(Busy), .Done(Done)
    );

    bar_stream_gen #(.NUM_COL(4), .COL_PER_BIN(1), .MAG_SHIFT(6), .GAP_EN(0)) dut2 (
        .Clock(Clock), .Reset(Reset), .FrameReq(FrameReq2), .Pace(Pace),
        .MagAddr(MagAddr2), .MagData(MagData2), .NewFrame(NewFrame2), .Start(Start2),
        .Bar(Bar2), .Busy(Busy2), .Done(Done2)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Spectrum RAM: one cycle read latency
    always @(posedge Clock) begin
        MagData  <= mem[MagAddr];
        MagData2 <= mem[MagAddr2];
    end

    initial begin
        Pace = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            case (pace_mode)
                0: Pace = 1'b0;
                1: begin
                    Pace = (pcnt == 9);
                    pcnt = (pcnt == 9) ? 0 : pcnt + 1;
                end
                2: Pace = 1'b1;
                default: Pace = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    always @(negedge Clock) begin
        if (Reset) in_frame = 1'b0;
        if (NewFrame === 1'b1) begin
            nf_cnt++;
            in_frame = 1'b1;
        end
        if (Busy !== in_frame) busy_err++;
        if (Start === 1'b1) begin
            start_cnt++;
            bar_h.push_back(Bar);
            addr_h.push_back(MagAddr);
            cyc_h.push_back(cyc);
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            in_frame = 1'b0;
        end
        if (NewFrame2 === 1'b1) nf2_cnt++;
        if (Start2 === 1'b1) begin
            start2_cnt++;
            bar2_h.push_back(Bar2);
            addr2_h.push_back(MagAddr2);
            cyc2_h.push_back(cyc);
        end
        if (Done2 === 1'b1) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference height: shifted magnitude clamped to 127, zero on the bin's last column when gapped
    function automatic int exp_bar(input int mag, input int c, input int cpb, input bit gap);
        int s;
        s = mag >> 6;
        if (gap && (c % cpb == cpb - 1)) return 0;
        return (s > 127) ? 127 : s;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask

    task automatic pulse_req(input bit second);
        cycles(1);
        if (second) FrameReq2 = 1'b1; else FrameReq = 1'b1;
        cycles(1);
        FrameReq  = 1'b0;
        FrameReq2 = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            cycles(1);
            n++;
        end
        if (start_cnt < target) chk(tag, start_cnt, target);
    endtask

    task automatic wait_done(input int db, input int budget, input string tag);
        int n = 0;
        while (done_cnt == db && n < budget) begin
            cycles(1);
            n++;
        end
        if (done_cnt == db) chk(tag, 0, 1);
        cycles(20);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_magaddr"}, MagAddr, 0);
        chk({tag, "_bar"}, Bar, 0);
        chk({tag, "_newframe"}, NewFrame, 0);
        chk({tag, "_start"}, Start, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
    endtask

    task automatic check_frame(input int sb, input int nb, input int db, input string nm, input bit exact4);
        chk({nm, "_newframes"}, nf_cnt - nb, 1);
        chk({nm, "_starts"}, start_cnt - sb, 800);
        chk({nm, "_dones"}, done_cnt - db, 1);
        for (int c = 0; c < 800; c++) begin
            if (sb + c < bar_h.size()) begin
                chk($sformatf("%s_bar%0d", nm, c), bar_h[sb + c], exp_bar(mem[c / 8], c, 8, 1'b1));
                chk($sformatf("%s_addr%0d", nm, c), addr_h[sb + c], c / 8);
                if (c > 0) begin
                    if (exact4)
                        chk($sformatf("%s_gap%0d", nm, c), cyc_h[sb + c] - cyc_h[sb + c - 1], 4);
                    else
                        chk($sformatf("%s_mingap%0d", nm, c), (cyc_h[sb + c] - cyc_h[sb + c - 1]) >= 4, 1);
                end
            end
        end
        if (sb + 799 < cyc_h.size())
            chk({nm, "_done_after_last"}, done_cyc, cyc_h[sb + 799] + 1);
    endtask

    initial begin
        int sb, nb, db;
        Reset = 1'b1;
        FrameReq = 1'b0;
        FrameReq2 = 1'b0;
        for (int b = 0; b < 128; b++) mem[b] = 16'(b * 64);
        #1;
        check_zero_outputs("reset");
        cycles(3);
        Reset = 1'b0;
        cycles(3);

        // Frame A: Pace every 10 cycles, MagData = bin*64
        sb = start_cnt; nb = nf_cnt; db = done_cnt;
        pace_mode = 1;
        pulse_req(1'b0);
        wait_done(db, 12000, "A_timeout");
        check_frame(sb, nb, db, "A", 1'b0);
        if (sb + 14 < bar_h.size()) begin
            chk("A_col0", bar_h[sb], 0);
            chk("A_col7_gap", bar_h[sb + 7], 0);
            chk("A_col8", bar_h[sb + 8], 1);
            chk("A_col14", bar_h[sb + 14], 1);
        end

        // Frame B: random magnitudes with clamp boundaries, random Pace
        for (int b = 0; b < 128; b++) mem[b] = 16'($urandom);
        mem[0] = 16'hFFFF;
        mem[1] = 16'd8191;
        mem[2] = 16'd8127;
        sb = start_cnt; nb = nf_cnt; db = done_cnt;
        pace_mode = 3;
        pulse_req(1'b0);
        wait_done(db, 20000, "B_timeout");
        check_frame(sb, nb, db, "B", 1'b0);
        if (sb + 16 < bar_h.size()) begin
            chk("B_ffff", bar_h[sb], 127);
            chk("B_8191", bar_h[sb + 8], 127);
            chk("B_8127", bar_h[sb + 16], 126);
        end

        // Frame C: Pace held high, extra FrameReq at column 300
        sb = start_cnt; nb = nf_cnt; db = done_cnt;
        pace_mode = 2;
        pulse_req(1'b0);
        wait_starts(sb + 300, 4000, "C_timeout300");
        pulse_req(1'b0);
        wait_done(db, 4000, "C_timeout");
        check_frame(sb, nb, db, "C", 1'b1);

        // Frame D: Reset after the 500th Start
        sb = start_cnt; nb = nf_cnt; db = done_cnt;
        pace_mode = 2;
        pulse_req(1'b0);
        wait_starts(sb + 500, 4000, "D_timeout500");
        Reset = 1'b1;
        #1;
        check_zero_outputs("D_reset");
        cycles(3);
        Reset = 1'b0;
        cycles(60);
        chk("D_starts", start_cnt - sb, 500);
        chk("D_dones", done_cnt - db, 0);
        chk("D_newframes", nf_cnt - nb, 1);

        // Frame E: full frame after the aborted one
        for (int b = 0; b < 128; b++) mem[b] = 16'($urandom);
        sb = start_cnt; nb = nf_cnt; db = done_cnt;
        pulse_req(1'b0);
        wait_done(db, 4000, "E_timeout");
        check_frame(sb, nb, db, "E", 1'b1);

        // Small instance: 4 columns, one column per bin, no gap
        for (int b = 0; b < 4; b++) mem[b] = 16'($urandom);
        mem[3] = 16'd127;
        pulse_req(1'b1);
        begin
            int n = 0;
            while (done2_cnt == 0 && n < 200) begin
                cycles(1);
                n++;
            end
        end
        cycles(10);
        chk("S_newframes", nf2_cnt, 1);
        chk("S_starts", start2_cnt, 4);
        chk("S_dones", done2_cnt, 1);
        for (int c = 0; c < 4; c++) begin
            if (c < bar2_h.size()) begin
                chk($sformatf("S_addr%0d", c), addr2_h[c], c);
                chk($sformatf("S_bar%0d", c), bar2_h[c], exp_bar(mem[c], c, 1, 1'b0));
            end
        end
        if (cyc2_h.size() >= 4) chk("S_done_after_last", done2_cyc, cyc2_h[3] + 1);

        chk("busy_window", busy_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
